quad_cmd_responder: RTL and testbench

//  Airframe-side end of the host command link: receives 3-byte packets {cmd, data_hi, data_lo} over UART 8N1.

---
 rtl/quad_cmd_responder_if.sv | 21 ++
 rtl/quad_cmd_responder.sv | 210 +++++++++++++++++++++
 tb/tb_quad_cmd_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/quad_cmd_responder_if.sv
// quad_cmd_responder_if: serial link pins plus flight-controller setpoint/calibration signals.
interface quad_cmd_responder_if;
    logic        RX;
    logic        TX;
    logic [15:0] ptch;
    logic [15:0] roll;
    logic [15:0] yaw;
    logic [8:0]  thrst;
    logic        strt_cal;
    logic        inertial_cal;
    logic        cal_done;
    logic        motors_off;
    modport slave (
        input  RX, cal_done,
        output TX, ptch, roll, yaw, thrst, strt_cal, inertial_cal, motors_off
    );
    modport master (
        output RX, cal_done,
        input  TX, ptch, roll, yaw, thrst, strt_cal, inertial_cal, motors_off
    );
endinterface

// File: rtl/quad_cmd_responder.sv
// quad_cmd_responder: UART 8N1 command decoder driving flight setpoints, with ack/nak replies and a link watchdog.
module quad_cmd_responder #(
    parameter int BAUD_DIV = 2604,
    parameter int BYTE_TO  = 2**20,
    parameter int WDOG_TO  = 2**26
) (
    input logic clk,
    input logic rst,
    quad_cmd_responder_if.slave bus
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(BYTE_TO) + 1;
    localparam int WW = $clog2(WDOG_TO) + 1;

    typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, EXEC, WAIT_CAL, RESP} state_t;
    state_t state, nxt;

    logic [2:0]    rx_s;
    logic          rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx, rx_smp, rx_rdy, rx_err;
    logic [TW-1:0] to_cnt;
    logic          in_get, to_exp;
    logic [7:0]    cmd;
    logic [15:0]   data;
    logic [15:0]   ptch, roll, yaw;
    logic [8:0]    thrst;
    logic          strt_cal, inertial_cal, motors_off;
    logic [WW-1:0] wd_cnt;
    logic          wd_clr, wd_fire;
    logic          tx_q, tx_busy, tx_load, tx_done;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;
    logic [7:0]    resp;

    assign rx     = rx_s[1];
    assign rx_smp = rx_busy && rx_cnt == '0;
    assign rx_rdy = rx_smp && rx_bit == 4'd9 && rx;
    assign rx_err = rx_smp && rx_bit == 4'd9 && !rx;

    // rx_s[2] is the previous synchronized level, used for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s    <= 3'b111;
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
        end else begin
            rx_s <= {rx_s[1:0], bus.RX};
            if (!rx_busy) begin
                if (rx_s[2] && !rx_s[1]) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= CW'(BAUD_DIV / 2 - 1);
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= CW'(BAUD_DIV - 1);
                rx_bit <= rx_bit + 1'b1;
                if ((rx_bit == 4'd0 && rx) || rx_bit == 4'd9)
                    rx_busy <= 1'b0;
                if (rx_bit >= 4'd1 && rx_bit <= 4'd8)
                    rx_sh <= {rx, rx_sh[7:1]};
            end
        end
    end

    // inter-byte timer pauses while a byte is arriving, so it measures stop-to-start gaps
    assign in_get = state == GET_HI || state == GET_LO;
    assign to_exp = in_get && !rx_busy && to_cnt == TW'(BYTE_TO - 1);

    always_ff @(posedge clk) begin
        if (rst)
            to_cnt <= '0;
        else
            to_cnt <= (rx_rdy || !in_get) ? '0 : rx_busy ? to_cnt : to_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt      = state;
        strt_cal = 1'b0;
        case (state)
            IDLE:     nxt = rx_rdy ? GET_HI : IDLE;
            GET_HI:   nxt = rx_rdy ? GET_LO : (rx_err || to_exp) ? IDLE : GET_HI;
            GET_LO:   nxt = rx_rdy ? EXEC : (rx_err || to_exp) ? IDLE : GET_LO;
            EXEC: begin
                nxt      = cmd == 8'h06 ? WAIT_CAL : RESP;
                strt_cal = cmd == 8'h06;
            end
            WAIT_CAL: nxt = bus.cal_done ? RESP : WAIT_CAL;
            RESP:     nxt = tx_done ? IDLE : RESP;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd  <= '0;
            data <= '0;
        end else if (rx_rdy) begin
            if (state == IDLE)   cmd        <= rx_sh;
            if (state == GET_HI) data[15:8] <= rx_sh;
            if (state == GET_LO) data[7:0]  <= rx_sh;
        end
    end

    assign wd_clr  = state == EXEC || motors_off || inertial_cal;
    assign wd_fire = !wd_clr && wd_cnt == WW'(WDOG_TO - 1);

    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_clr ? '0 : wd_cnt == WW'(WDOG_TO) ? wd_cnt : wd_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptch         <= '0;
            roll         <= '0;
            yaw          <= '0;
            thrst        <= '0;
            inertial_cal <= 1'b0;
            motors_off   <= 1'b1;
        end else if (state == EXEC) begin
            case (cmd)
                8'h02: ptch <= data;
                8'h03: roll <= data;
                8'h04: yaw <= data;
                8'h05: thrst <= data[8:0];
                8'h06: inertial_cal <= 1'b1;
                8'h07: begin
                    ptch  <= '0;
                    roll  <= '0;
                    yaw   <= '0;
                    thrst <= '0;
                end
                8'h08: begin
                    motors_off <= 1'b1;
                    thrst      <= '0;
                end
                default: ;
            endcase
        end else begin
            if (wd_fire) begin
                ptch  <= '0;
                roll  <= '0;
                yaw   <= '0;
                thrst <= '0;
            end
            if (state == WAIT_CAL && bus.cal_done) begin
                inertial_cal <= 1'b0;
                motors_off   <= 1'b0;
            end
        end
    end

    assign resp    = cmd inside {[8'h02:8'h08]} ? 8'hA5 : 8'hEE;
    assign tx_load = state == RESP && !tx_busy;
    assign tx_done = tx_busy && tx_bit == 4'd9 && tx_cnt == CW'(BAUD_DIV - 1);

    // tx_sh carries the data bits followed by a 1 that becomes the stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q    <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '1;
        end else if (tx_load) begin
            tx_q    <= 1'b0;
            tx_busy <= 1'b1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= {1'b1, resp};
        end else if (tx_busy) begin
            if (tx_cnt == CW'(BAUD_DIV - 1)) begin
                tx_cnt <= '0;
                tx_bit <= tx_bit + 1'b1;
                tx_q   <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[8:1]};
                if (tx_bit == 4'd9)
                    tx_busy <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign bus.TX           = tx_q;
    assign bus.ptch         = ptch;
    assign bus.roll         = roll;
    assign bus.yaw          = yaw;
    assign bus.thrst        = thrst;
    assign bus.strt_cal     = strt_cal;
    assign bus.inertial_cal = inertial_cal;
    assign bus.motors_off   = motors_off;
endmodule

// File: tb/tb_quad_cmd_responder.sv
// tb_quad_cmd_responder: directed and random packets against a behavioural model of the command responder.
module tb_quad_cmd_responder;
    localparam int B    = 16;
    localparam int BTO  = 300;
    localparam int WDOG = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int pulses = 0;
    logic [8:0] rxq[$];

    logic [15:0] mp, mr, my;
    logic [8:0]  mt;
    logic        mmo, mic;

    quad_cmd_responder_if bus();

    quad_cmd_responder #(.BAUD_DIV(B), .BYTE_TO(BTO), .WDOG_TO(WDOG)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.strt_cal === 1'b1) pulses++;

    // UART receiver for the DUT's replies: pushes {stop_bit, byte}
    initial begin
        logic [7:0] mb;
        logic ms;
        forever begin
            @(negedge clk);
            if (!rst && bus.TX === 1'b0) begin
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    mb[i] = bus.TX;
                end
                repeat (B) @(negedge clk);
                ms = bus.TX;
                rxq.push_back({ms, mb});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ptch"}, bus.ptch, mp);
        chk({tag, "_roll"}, bus.roll, mr);
        chk({tag, "_yaw"}, bus.yaw, my);
        chk({tag, "_thrst"}, bus.thrst, mt);
        chk({tag, "_motors_off"}, bus.motors_off, mmo);
        chk({tag, "_inertial_cal"}, bus.inertial_cal, mic);
        chk({tag, "_tx_idle"}, bus.TX, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        bus.RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            repeat (B) @(negedge clk);
        end
        bus.RX = stop;
        repeat (B) @(negedge clk);
        bus.RX = 1'b1;
        repeat (2 * B) @(negedge clk);
    endtask

    task automatic get_resp(input string tag, input logic [7:0] exp);
        int n = 0;
        while (rxq.size() == 0 && n < 30 * B) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_resp_present"}, rxq.size() != 0, 1);
        if (rxq.size() != 0) chk({tag, "_resp_byte"}, rxq.pop_front(), {1'b1, exp});
    endtask

    task automatic pkt(input string tag, input logic [7:0] c, input logic [15:0] d);
        int p0 = pulses;
        logic [7:0] rsp = (c >= 8'h02 && c <= 8'h08) ? 8'hA5 : 8'hEE;
        send_byte(c, 1'b1);
        send_byte(d[15:8], 1'b1);
        send_byte(d[7:0], 1'b1);
        case (c)
            8'h02: mp = d;
            8'h03: mr = d;
            8'h04: my = d;
            8'h05: mt = d[8:0];
            8'h07: begin mp = 0; mr = 0; my = 0; mt = 0; end
            8'h08: begin mmo = 1; mt = 0; end
            default: ;
        endcase
        chk({tag, "_strt_cal_pulses"}, pulses - p0, (c == 8'h06) ? 1 : 0);
        if (c == 8'h06) begin
            repeat (10 * B) @(negedge clk);
            chk({tag, "_cal_active"}, bus.inertial_cal, 1'b1);
            chk({tag, "_cal_no_tx"}, rxq.size(), 0);
            bus.cal_done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.cal_done = 1'b0;
            chk({tag, "_cal_clear"}, {bus.inertial_cal, bus.motors_off, bus.TX}, 3'b001);
            @(negedge clk);
            chk({tag, "_tx_start_latency"}, bus.TX, 1'b0);
            mmo = 0;
            mic = 0;
        end
        get_resp(tag, rsp);
        check_state(tag);
    endtask

    initial begin
        logic [7:0] pool [9] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0B, 8'h00};
        logic [7:0] c;
        bus.RX = 1'b1;
        bus.cal_done = 1'b0;
        mp = 0; mr = 0; my = 0; mt = 0; mmo = 1; mic = 0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("reset");
        chk("reset_strt_cal", bus.strt_cal, 1'b0);

        bus.cal_done = 1'b1;
        @(negedge clk);
        bus.cal_done = 1'b0;
        repeat (3) @(negedge clk);
        check_state("stray_cal_done");

        pkt("t1", 8'h02, 16'h0100);
        pkt("t2", 8'h06, 16'($urandom));
        pkt("t3a", 8'h05, 16'h00FF);
        pkt("t3b", 8'h07, 16'h0000);
        pkt("t4_nak", 8'h0B, 16'($urandom));

        send_byte(8'h02, 1'b1);
        send_byte(8'hAA, 1'b0);
        repeat (10 * B) @(negedge clk);
        chk("t4_framing_quiet", rxq.size(), 0);
        pkt("t4_after_framing", 8'h04, 16'h1234);

        send_byte(8'h03, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (BTO + 200) @(negedge clk);
        chk("t5_timeout_quiet", rxq.size(), 0);
        pkt("t5", 8'h03, 16'hFF80);
        repeat (15 * B) @(negedge clk);
        chk("t5_single_resp", rxq.size(), 0);

        for (int k = 0; k < 12; k++) begin
            int idx = $urandom_range(0, 8);
            c = (idx == 8) ? 8'($urandom) : pool[idx];
            pkt("rand", c, 16'($urandom));
        end

        pkt("t6_cal", 8'h06, 16'h0000);
        pkt("t6_ptch", 8'h02, 16'($urandom));
        pkt("t6_thrst", 8'h05, 16'h00FF);
        repeat (WDOG - 400) @(negedge clk);
        chk("t6_wdog_not_yet", bus.thrst, 9'h0FF);
        repeat (600) @(negedge clk);
        mp = 0; mr = 0; my = 0; mt = 0;
        check_state("t6_wdog");
        chk("t6_wdog_no_tx", rxq.size(), 0);

        send_byte(8'h03, 1'b1);
        @(negedge clk);
        bus.RX = 1'b0;
        repeat (3 * B + 5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        bus.RX = 1'b1;
        mp = 0; mr = 0; my = 0; mt = 0; mmo = 1; mic = 0;
        check_state("t6_rst");
        chk("t6_rst_strt_cal", bus.strt_cal, 1'b0);
        rst = 1'b0;
        repeat (2 * B) @(negedge clk);
        rxq.delete();
        pkt("t6_post_rst", 8'h02, 16'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
